// File: rtl/router_pkg.sv
// Shared router definitions: header field layout, data width, reader states.
// Imported by the destination reader and its parity checker.
package router_pkg;

    localparam int DATA_W   = 8;
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;
    localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
    localparam int MAX_TIME = 30;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        HDR   = 3'd2,
        BODY  = 3'd3,
        DONE  = 3'd4
    } rd_state_e;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
        return hdr[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR over header and payload; seed loads, accumulate folds in din.
// mismatch compares din against the running value combinationally; never stalls.
module router_parity_chk
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              seed,
    input  logic              accumulate,
    input  logic [DATA_W-1:0] din,
    output logic              mismatch
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (seed) begin
            acc_d = din;
        end else if (accumulate) begin
            acc_d = acc_q ^ din;
        end
        mismatch = (din != acc_q);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/router_dest_reader.sv
// Drains one packet per enable from a router output port with paced read_en pulses,
// checks parity/address; data lands one cycle after a read; stalls while vld_out is low.
module router_dest_reader
    import router_pkg::*;
#(
    parameter int PORT_ID    = 0,
    parameter int READ_DELAY = 5,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              enable,
    input  logic              vld_out,
    input  logic              soft_reset,
    input  logic [DATA_W-1:0] data_out,
    output logic              read_en,
    output logic [DATA_W-1:0] byte_out,
    output logic              byte_valid,
    output logic              pkt_done,
    output logic [LEN_W-1:0]  pkt_len,
    output logic [ADDR_W-1:0] pkt_addr,
    output logic              parity_err,
    output logic              addr_err,
    output logic              abort,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam logic [ADDR_W-1:0] PORT_ADDR = ADDR_W'(PORT_ID);
    localparam int DCNT_W = (READ_DELAY > 2) ? $clog2(READ_DELAY) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'((READ_DELAY > 0) ? READ_DELAY - 1 : 0);
    localparam int RL_W = LEN_W + 1;

    rd_state_e         state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              rd_q, rd_d;
    logic [RL_W-1:0]   reads_left_q, reads_left_d;
    logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
    logic [ADDR_W-1:0] pkt_addr_q, pkt_addr_d;
    logic [DATA_W-1:0] byte_out_q, byte_out_d;
    logic              byte_valid_q, byte_valid_d;
    logic              abort_q, abort_d;
    logic              perr_q, perr_d;
    logic              aerr_q, aerr_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;

    logic capture;
    logic par_seed;
    logic par_acc;
    logic par_mismatch;

    router_parity_chk u_parity (
        .clock      (clock),
        .resetn     (resetn),
        .seed       (par_seed),
        .accumulate (par_acc),
        .din        (data_out),
        .mismatch   (par_mismatch)
    );

    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        reads_left_d = reads_left_q;
        pkt_len_d    = pkt_len_q;
        pkt_addr_d   = pkt_addr_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        abort_d      = 1'b0;
        perr_d       = perr_q;
        aerr_d       = aerr_q;
        pkt_count_d  = pkt_count_q;
        par_seed     = 1'b0;
        par_acc      = 1'b0;

        // One read per two cycles: rd_q blocks back-to-back pops so vld_out settles first.
        read_en = ((state_q == HDR) || (state_q == BODY)) && vld_out && !rd_q &&
                  (reads_left_q != '0) && !soft_reset;
        rd_d    = read_en;
        capture = rd_q && !soft_reset;

        if (soft_reset && ((state_q == DELAY) || (state_q == HDR) || (state_q == BODY))) begin
            state_d = IDLE;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && vld_out && !soft_reset) begin
                        dcnt_d       = '0;
                        reads_left_d = RL_W'(1);
                        state_d      = (READ_DELAY == 0) ? HDR : DELAY;
                    end
                end
                DELAY: begin
                    if (dcnt_q == DCNT_LAST) begin
                        state_d = HDR;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
                HDR: begin
                    if (capture) begin
                        pkt_len_d    = hdr_len(data_out);
                        pkt_addr_d   = hdr_addr(data_out);
                        par_seed     = 1'b1;
                        reads_left_d = {1'b0, hdr_len(data_out)} + RL_W'(1);
                        state_d      = BODY;
                    end
                end
                BODY: begin
                    if (capture) begin
                        reads_left_d = reads_left_q - RL_W'(1);
                        if (reads_left_q > RL_W'(1)) begin
                            byte_out_d   = data_out;
                            byte_valid_d = 1'b1;
                            par_acc      = 1'b1;
                        end else begin
                            perr_d  = par_mismatch;
                            aerr_d  = (pkt_addr_q != PORT_ADDR);
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    pkt_count_d = pkt_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= IDLE;
            dcnt_q       <= '0;
            rd_q         <= 1'b0;
            reads_left_q <= '0;
            pkt_len_q    <= '0;
            pkt_addr_q   <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            abort_q      <= 1'b0;
            perr_q       <= 1'b0;
            aerr_q       <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            rd_q         <= rd_d;
            reads_left_q <= reads_left_d;
            pkt_len_q    <= pkt_len_d;
            pkt_addr_q   <= pkt_addr_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            abort_q      <= abort_d;
            perr_q       <= perr_d;
            aerr_q       <= aerr_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign pkt_done   = (state_q == DONE);
    assign parity_err = (state_q == DONE) && perr_q;
    assign addr_err   = (state_q == DONE) && aerr_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_addr   = pkt_addr_q;
    assign abort      = abort_q;
    assign busy       = (state_q != IDLE);
    assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_router_dest_reader.sv
// Two readers share one modelled port FIFO: dut0 (port 0, delay 5) runs the packet table,
// dut1 (port 1, delay 35, 2-bit count) covers soft-reset abort and count wrap.
module tb_router_dest_reader;

    logic       clock = 1'b0;
    logic       resetn;
    logic       vld_out;
    logic [7:0] data_out;
    logic       enable     [2];
    logic       soft_reset [2];

    logic       read_en_s    [2];
    logic [7:0] byte_out_s   [2];
    logic       byte_valid_s [2];
    logic       pkt_done_s   [2];
    logic [5:0] pkt_len_s    [2];
    logic [1:0] pkt_addr_s   [2];
    logic       parity_err_s [2];
    logic       addr_err_s   [2];
    logic       abort_s      [2];
    logic       busy_s       [2];
    logic [15:0] pkt_count0;
    logic [1:0]  pkt_count1;

    always #5 clock = ~clock;

    router_dest_reader #(.PORT_ID(0), .READ_DELAY(5), .CNT_W(16)) dut0 (
        .clock(clock), .resetn(resetn), .enable(enable[0]), .vld_out(vld_out),
        .soft_reset(soft_reset[0]), .data_out(data_out), .read_en(read_en_s[0]),
        .byte_out(byte_out_s[0]), .byte_valid(byte_valid_s[0]), .pkt_done(pkt_done_s[0]),
        .pkt_len(pkt_len_s[0]), .pkt_addr(pkt_addr_s[0]), .parity_err(parity_err_s[0]),
        .addr_err(addr_err_s[0]), .abort(abort_s[0]), .busy(busy_s[0]), .pkt_count(pkt_count0)
    );

    router_dest_reader #(.PORT_ID(1), .READ_DELAY(35), .CNT_W(2)) dut1 (
        .clock(clock), .resetn(resetn), .enable(enable[1]), .vld_out(vld_out),
        .soft_reset(soft_reset[1]), .data_out(data_out), .read_en(read_en_s[1]),
        .byte_out(byte_out_s[1]), .byte_valid(byte_valid_s[1]), .pkt_done(pkt_done_s[1]),
        .pkt_len(pkt_len_s[1]), .pkt_addr(pkt_addr_s[1]), .parity_err(parity_err_s[1]),
        .addr_err(addr_err_s[1]), .abort(abort_s[1]), .busy(busy_s[1]), .pkt_count(pkt_count1)
    );

    // Port FIFO model: data valid the cycle after a read, vld_out is registered ~empty.
    logic [7:0] fifo [$];
    always @(posedge clock) begin
        if (!resetn) begin
            vld_out  <= 1'b0;
            data_out <= 8'h00;
        end else begin
            if ((read_en_s[0] || read_en_s[1]) && fifo.size() != 0)
                data_out <= fifo.pop_front();
            vld_out <= (fifo.size() != 0);
        end
    end

    int cyc = 0;
    int reads [2];
    int bytes [2];
    int dones [2];
    int aborts [2];
    int stall_reads, last_rd, min_gap, first_busy, first_rd;
    logic stalling = 1'b0;
    logic [5:0] d_len [2];
    logic [1:0] d_addr [2];
    logic d_pe [2];
    logic d_ae [2];
    logic [7:0] got [$];

    always @(negedge clock) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (read_en_s[i] === 1'b1) reads[i] = reads[i] + 1;
            if (byte_valid_s[i] === 1'b1) bytes[i] = bytes[i] + 1;
            if (abort_s[i] === 1'b1) aborts[i] = aborts[i] + 1;
            if (pkt_done_s[i] === 1'b1) begin
                dones[i]  = dones[i] + 1;
                d_len[i]  = pkt_len_s[i];
                d_addr[i] = pkt_addr_s[i];
                d_pe[i]   = parity_err_s[i];
                d_ae[i]   = addr_err_s[i];
            end
        end
        if (busy_s[0] === 1'b1 && first_busy < 0) first_busy = cyc;
        if (read_en_s[0] === 1'b1) begin
            if (first_rd < 0) first_rd = cyc;
            if (last_rd >= 0 && (cyc - last_rd) < min_gap) min_gap = cyc - last_rd;
            last_rd = cyc;
            if (stalling) stall_reads = stall_reads + 1;
        end
        if (byte_valid_s[0] === 1'b1) got.push_back(byte_out_s[0]);
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            reads[i] = 0; bytes[i] = 0; dones[i] = 0; aborts[i] = 0;
        end
        stall_reads = 0; last_rd = -1; min_gap = 1000; first_busy = -1; first_rd = -1;
        got.delete();
    endtask

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] pl [4];
        logic [7:0] par;
        int         split;
        int         len;
        logic [1:0] addr;
        logic       pe;
        logic       ae;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] h, input logic [7:0] p0, input logic [7:0] p1,
                                input logic [7:0] p2, input logic [7:0] p3, input logic [7:0] par,
                                input int split, input int len, input logic [1:0] addr,
                                input logic pe, input logic ae);
        vec_t v;
        v.hdr = h; v.pl[0] = p0; v.pl[1] = p1; v.pl[2] = p2; v.pl[3] = p3;
        v.par = par; v.split = split; v.len = len; v.addr = addr; v.pe = pe; v.ae = ae;
        return v;
    endfunction

    int exp_count = 0;

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int first_part;
        clr();
        first_part = (v.split > 0) ? v.split : v.len;
        fifo.push_back(v.hdr);
        for (int k = 0; k < first_part; k++) fifo.push_back(v.pl[k]);
        if (v.split == 0) fifo.push_back(v.par);
        enable[0] = 1'b1;
        if (v.split > 0) begin
            n = 0;
            while (bytes[0] < v.split && n < 300) begin tick(); n++; end
            check($sformatf("v%0d bytes before stall", idx), bytes[0], v.split);
            stalling = 1'b1;
            repeat (10) tick();
            stalling = 1'b0;
            check($sformatf("v%0d reads during stall", idx), stall_reads, 0);
            for (int k = v.split; k < v.len; k++) fifo.push_back(v.pl[k]);
            fifo.push_back(v.par);
        end
        n = 0;
        while (dones[0] == 0 && n < 400) begin tick(); n++; end
        enable[0] = 1'b0;
        tick(); tick();
        exp_count++;
        check($sformatf("v%0d pkt_done count", idx), dones[0], 1);
        check($sformatf("v%0d first read delay", idx), first_rd - first_busy, 5);
        check($sformatf("v%0d read_en pulses", idx), reads[0], v.len + 2);
        check($sformatf("v%0d min read gap ok", idx), (min_gap >= 2), 1);
        check($sformatf("v%0d byte_valid count", idx), got.size(), v.len);
        for (int k = 0; k < v.len && k < got.size(); k++)
            check($sformatf("v%0d byte %0d", idx, k), got[k], v.pl[k]);
        check($sformatf("v%0d pkt_len", idx), d_len[0], v.len);
        check($sformatf("v%0d pkt_addr", idx), d_addr[0], v.addr);
        check($sformatf("v%0d parity_err", idx), d_pe[0], v.pe);
        check($sformatf("v%0d addr_err", idx), d_ae[0], v.ae);
        check($sformatf("v%0d pkt_count", idx), pkt_count0, exp_count);
        check($sformatf("v%0d busy after", idx), busy_s[0], 1'b0);
    endtask

    vec_t vecs [6];

    initial begin
        int n;
        vecs[0] = mk(8'h0C, 8'h11, 8'h22, 8'h33, 8'h00, 8'h0C, 0, 3, 2'd0, 1'b0, 1'b0);
        vecs[1] = mk(8'h0C, 8'h11, 8'h22, 8'h33, 8'h00, 8'h0D, 0, 3, 2'd0, 1'b1, 1'b0);
        vecs[2] = mk(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 2'd1, 1'b0, 1'b1);
        vecs[3] = mk(8'h0C, 8'h11, 8'h22, 8'h33, 8'h00, 8'h0C, 2, 3, 2'd0, 1'b0, 1'b0);
        vecs[4] = mk(8'h06, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA3, 0, 1, 2'd2, 1'b0, 1'b1);
        vecs[5] = mk(8'h10, 8'h01, 8'h02, 8'h04, 8'h08, 8'h1F, 0, 4, 2'd0, 1'b0, 1'b0);

        resetn = 1'b0;
        enable[0] = 1'b0; enable[1] = 1'b0;
        soft_reset[0] = 1'b0; soft_reset[1] = 1'b0;
        clr();
        repeat (3) tick();
        resetn = 1'b1;
        @(negedge clock);
        check("reset busy0", busy_s[0], 1'b0);
        check("reset count0", pkt_count0, 16'h0000);
        check("reset outs1", {busy_s[1], read_en_s[1], pkt_done_s[1], abort_s[1], pkt_count1}, 6'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Soft reset while dut1 sits in its long delay.
        clr();
        fifo.push_back(8'h01); fifo.push_back(8'h01);
        enable[1] = 1'b1;
        n = 0;
        while (busy_s[1] !== 1'b1 && n < 50) begin tick(); n++; end
        check("sr busy entered", busy_s[1], 1'b1);
        enable[1] = 1'b0;
        repeat (10) tick();
        soft_reset[1] = 1'b1;
        tick();
        soft_reset[1] = 1'b0;
        @(negedge clock);
        check("sr abort pulse", abort_s[1], 1'b1);
        check("sr busy cleared", busy_s[1], 1'b0);
        @(negedge clock);
        check("sr abort width", abort_s[1], 1'b0);
        check("sr no reads", reads[1], 0);
        check("sr no done", dones[1], 0);
        check("sr count held", pkt_count1, 2'd0);

        // Four zero-length packets to dut1 walk its 2-bit counter through the wrap.
        fifo.delete();
        tick(); tick();
        for (int p = 0; p < 4; p++) begin
            clr();
            fifo.push_back(8'h01); fifo.push_back(8'h01);
            enable[1] = 1'b1;
            n = 0;
            while (dones[1] == 0 && n < 200) begin tick(); n++; end
            enable[1] = 1'b0;
            tick(); tick();
            check($sformatf("p%0d done", p), dones[1], 1);
            check($sformatf("p%0d reads", p), reads[1], 2);
            check($sformatf("p%0d bytes", p), bytes[1], 0);
            check($sformatf("p%0d errs", p), {d_pe[1], d_ae[1]}, 2'b00);
            check($sformatf("p%0d count", p), pkt_count1, (p + 1) % 4);
        end

        // Synchronous reset in the middle of a body on dut0.
        clr();
        fifo.push_back(8'h0C); fifo.push_back(8'h11); fifo.push_back(8'h22);
        fifo.push_back(8'h33); fifo.push_back(8'h0C);
        enable[0] = 1'b1;
        n = 0;
        while (bytes[0] < 1 && n < 200) begin tick(); n++; end
        check("rst reached body", busy_s[0], 1'b1);
        enable[0] = 1'b0;
        resetn = 1'b0;
        fifo.delete();
        tick();
        @(negedge clock);
        check("rst ctrl outs", {read_en_s[0], busy_s[0], byte_valid_s[0], pkt_done_s[0],
                                parity_err_s[0], addr_err_s[0], abort_s[0]}, 7'd0);
        check("rst data outs", {byte_out_s[0], pkt_len_s[0], pkt_addr_s[0], pkt_count0}, 32'd0);
        resetn = 1'b1;
        tick(); tick();
        exp_count = 0;
        run_vec(vecs[0], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
